// File: rtl/topk_pkg.sv
// Shared types for the streaming top-K selector: FSM states, slot record, empty-slot value.
package topk_pkg;

  localparam int SLOT_DATA_W = 14;
  localparam int SLOT_IDX_W  = 6;
  localparam int SLOT_GRP_W  = SLOT_IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_DATA_W-1:0] data;
    logic [SLOT_IDX_W-1:0]  idx;
    logic [SLOT_GRP_W-1:0]  grp;
  } slot_t;

  // Empty slots present data 0 and an all-ones index.
  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, data: '0, idx: '1, grp: '0};

endpackage

// File: rtl/topk_if.sv
// Sample stream in, result record out, between readout buffer and address generator.
interface topk_if #(
  parameter int DATA_W = 14,
  parameter int IDX_W  = 6,
  parameter int K      = 4,
  parameter int CNT_W  = $clog2(K + 1)
);
  // A beat moves on a rising edge where valid and ready are both high; the
  // sender holds valid and data stable until then, ready may change freely.
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [K*DATA_W-1:0]  out_data;
  logic [K*IDX_W-1:0]   out_idx;
  logic [CNT_W-1:0]     out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_count
  );
endinterface

// File: rtl/topk_slot_cmp.sv
// Compares one stored slot with the incoming sample: ordering and group match.
module topk_slot_cmp
  import topk_pkg::*;
(
  input  slot_t                  slot,
  input  logic [SLOT_DATA_W-1:0] data,
  input  logic [SLOT_GRP_W-1:0]  grp,
  input  logic                   max_mode,
  output logic                   better,
  output logic                   same_grp
);
  // Strict compare so an equal later sample never overtakes an earlier one.
  assign better   = slot.valid && (max_mode ? (data > slot.data) : (data < slot.data));
  assign same_grp = slot.valid && (slot.grp == grp);
endmodule

// File: rtl/topk_select.sv
// Streaming top-K selector keeping at most one winner per group of GROUP indices.
module topk_select
  import topk_pkg::*;
#(
  parameter int DATA_W = SLOT_DATA_W,
  parameter int IDX_W  = SLOT_IDX_W,
  parameter int K      = 4,
  parameter int GROUP  = 3,
  parameter int GRP_W  = SLOT_GRP_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [IDX_W:0] cfg_len,
  input  logic           cfg_max,
  input  logic           cfg_skip_zero,
  topk_if.slave          bus,
  output logic           busy,
  output state_t         dbg_state
);
  localparam int CNT_W = $clog2(K + 1);
  localparam int PW    = $clog2(K + 1);

  state_t             state_q, state_d;
  slot_t              slots   [K];
  slot_t              slots_d [K];
  logic [IDX_W:0]     len_q;
  logic               max_q, skip_q;
  logic [IDX_W-1:0]   idx_q;
  logic [GRP_W-1:0]   grp_q, sub_q;
  logic [K-1:0]       better, same_grp;
  logic [PW-1:0]      p, m, e;
  logic               has_m, accept, last, insert;

  for (genvar i = 0; i < K; i++) begin : g_cmp
    topk_slot_cmp u_cmp (
      .slot     (slots[i]),
      .data     (bus.in_data),
      .grp      (grp_q),
      .max_mode (max_q),
      .better   (better[i]),
      .same_grp (same_grp[i])
    );
  end

  // Downward scan leaves p/m on the lowest matching slot.
  always_comb begin
    p     = PW'(K);
    m     = '0;
    has_m = 1'b0;
    for (int i = K - 1; i >= 0; i--) begin
      if (!slots[i].valid || better[i]) p = PW'(i);
      if (same_grp[i]) begin
        m     = PW'(i);
        has_m = 1'b1;
      end
    end
  end

  assign accept = (state_q == RUN) && bus.in_valid && !start;
  assign last   = ({1'b0, idx_q} == (len_q - 1'b1));
  assign insert = accept && !(skip_q && (bus.in_data == '0)) &&
                  (has_m ? (p <= m) : (p != PW'(K)));

  // Shift window ends at the same-group slot, or at the last slot which then drops.
  always_comb begin
    e = has_m ? m : PW'(K - 1);
    for (int i = 0; i < K; i++) begin
      slots_d[i] = slots[i];
      if (PW'(i) == p)
        slots_d[i] = '{valid: 1'b1, data: bus.in_data, idx: idx_q, grp: grp_q};
      else if ((PW'(i) > p) && (PW'(i) <= e))
        slots_d[i] = slots[(i == 0) ? 0 : i - 1];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (cfg_len == '0) ? DONE : RUN;
      RUN:     if (start) state_d = (cfg_len == '0) ? DONE : RUN;
               else if (accept && last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      max_q   <= 1'b0;
      skip_q  <= 1'b0;
      idx_q   <= '0;
      grp_q   <= '0;
      sub_q   <= '0;
      for (int i = 0; i < K; i++) slots[i] <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
      if (start && (state_q != DONE)) begin
        len_q  <= cfg_len;
        max_q  <= cfg_max;
        skip_q <= cfg_skip_zero;
        idx_q  <= '0;
        grp_q  <= '0;
        sub_q  <= '0;
        for (int i = 0; i < K; i++) slots[i] <= SLOT_EMPTY;
      end else if (accept) begin
        idx_q <= idx_q + 1'b1;
        if (sub_q == GRP_W'(GROUP - 1)) begin
          sub_q <= '0;
          grp_q <= grp_q + 1'b1;
        end else begin
          sub_q <= sub_q + 1'b1;
        end
        if (insert)
          for (int i = 0; i < K; i++) slots[i] <= slots_d[i];
      end
    end
  end

  assign bus.in_ready  = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

  always_comb begin
    bus.out_data  = '0;
    bus.out_idx   = '0;
    bus.out_count = '0;
    if (state_q == DONE) begin
      for (int i = 0; i < K; i++) begin
        bus.out_data[i*DATA_W +: DATA_W] = slots[i].data;
        bus.out_idx[i*IDX_W +: IDX_W]    = slots[i].idx;
        bus.out_count = bus.out_count + CNT_W'(slots[i].valid);
      end
    end
  end

endmodule
